// File: rtl/dot_product_collector.sv
// ----------------------------------------------------------------------------
// dot_product_collector
//
// Downstream stage of the 3-element serial dot-product engine. Samples the
// engine result bus on each frame-start strobe and queues completed results in
// a small first-word-fall-through FIFO with a valid/ready output. The first
// strobe after reset carries the engine's reset value and is discarded.
//
// Ports:
//   clk          clock
//   resetn       synchronous active-low reset (shared with the engine)
//   dp_dout      engine result bus
//   dp_run       engine frame-start strobe, one cycle per frame
//   out_data     FIFO head result
//   out_valid    FIFO non-empty
//   out_ready    consumer accepts the head this cycle
//   level        current FIFO occupancy
//   overflow     sticky: a result was dropped because the FIFO was full
//   spacing_err  sticky: dp_run period differed from VECTOR_SIZE
//   clear        clears both sticky flags
//   out_tag      head entry sequence tag (only with DP_COLLECT_TAG_EN)
//
// Build option:
//   DP_COLLECT_TAG_EN  adds a per-capture sequence tag stored with each entry.
// ----------------------------------------------------------------------------
module dot_product_collector #(
    parameter int unsigned DOUT_WIDTH  = 18,
    parameter int unsigned VECTOR_SIZE = 6,
    parameter int unsigned FIFO_DEPTH  = 4,
    parameter int unsigned TAG_WIDTH   = 8
) (
    input  logic                          clk,
    input  logic                          resetn,
    input  logic [DOUT_WIDTH-1:0]         dp_dout,
    input  logic                          dp_run,
    output logic [DOUT_WIDTH-1:0]         out_data,
    output logic                          out_valid,
    input  logic                          out_ready,
    output logic [$clog2(FIFO_DEPTH):0]   level,
    output logic                          overflow,
    output logic                          spacing_err,
    input  logic                          clear
`ifdef DP_COLLECT_TAG_EN
    ,
    output logic [TAG_WIDTH-1:0]          out_tag
`endif
);

    localparam int unsigned PtrW = $clog2(FIFO_DEPTH);
    localparam int unsigned LvlW = PtrW + 1;
    localparam int unsigned GapW = $clog2(VECTOR_SIZE + 1);

    localparam logic [GapW-1:0] GapLast = GapW'(VECTOR_SIZE - 1);
    localparam logic [GapW-1:0] GapMax  = GapW'(VECTOR_SIZE);
    localparam logic [LvlW-1:0] LvlFull = LvlW'(FIFO_DEPTH);

    logic                  armed_q, armed_d;
    logic [GapW-1:0]       gap_q, gap_d;
    logic [PtrW-1:0]       wr_ptr_q, wr_ptr_d;
    logic [PtrW-1:0]       rd_ptr_q, rd_ptr_d;
    logic [LvlW-1:0]       level_q, level_d;
    logic                  overflow_q, overflow_d;
    logic                  spacing_q, spacing_d;
    logic [DOUT_WIDTH-1:0] mem_q [FIFO_DEPTH];

    logic full, pop, capture, push, drop, spacing_set;

    always_comb begin
        pop     = (level_q != '0) & out_ready;
        full    = (level_q == LvlFull);
        capture = dp_run & armed_q;
        // When full, a simultaneous pop frees the slot the push needs.
        push    = capture & (~full | pop);
        drop    = capture & full & ~pop;

        armed_d = armed_q | dp_run;

        gap_d = gap_q;
        if (dp_run) begin
            gap_d = '0;
        end else if (armed_q && (gap_q != GapMax)) begin
            gap_d = gap_q + GapW'(1);
        end

        // Early/late strobe, or a missing strobe when one was due.
        spacing_set = armed_q & (dp_run ? (gap_q != GapLast) : (gap_q == GapLast));

        wr_ptr_d = push ? wr_ptr_q + PtrW'(1) : wr_ptr_q;
        rd_ptr_d = pop  ? rd_ptr_q + PtrW'(1) : rd_ptr_q;

        level_d = level_q;
        unique case ({push, pop})
            2'b10:   level_d = level_q + LvlW'(1);
            2'b01:   level_d = level_q - LvlW'(1);
            default: level_d = level_q;
        endcase

        // Set wins over clear.
        overflow_d = drop | (overflow_q & ~clear);
        spacing_d  = spacing_set | (spacing_q & ~clear);
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            armed_q    <= 1'b0;
            gap_q      <= '0;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            level_q    <= '0;
            overflow_q <= 1'b0;
            spacing_q  <= 1'b0;
        end else begin
            armed_q    <= armed_d;
            gap_q      <= gap_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            level_q    <= level_d;
            overflow_q <= overflow_d;
            spacing_q  <= spacing_d;
        end
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            for (int i = 0; i < int'(FIFO_DEPTH); i++) begin
                mem_q[i] <= '0;
            end
        end else if (push) begin
            mem_q[wr_ptr_q] <= dp_dout;
        end
    end

    assign out_data    = mem_q[rd_ptr_q];
    assign out_valid   = (level_q != '0);
    assign level       = level_q;
    assign overflow    = overflow_q;
    assign spacing_err = spacing_q;

`ifdef DP_COLLECT_TAG_EN
    logic [TAG_WIDTH-1:0] tag_cnt_q;
    logic [TAG_WIDTH-1:0] tag_mem_q [FIFO_DEPTH];

    // The counter advances on dropped captures too, so drops show as tag gaps.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            tag_cnt_q <= '0;
            for (int i = 0; i < int'(FIFO_DEPTH); i++) begin
                tag_mem_q[i] <= '0;
            end
        end else begin
            if (capture) begin
                tag_cnt_q <= tag_cnt_q + TAG_WIDTH'(1);
            end
            if (push) begin
                tag_mem_q[wr_ptr_q] <= tag_cnt_q;
            end
        end
    end

    assign out_tag = tag_mem_q[rd_ptr_q];
`else
    localparam int unsigned UnusedTagWidth = TAG_WIDTH;
`endif

endmodule

// File: tb/tb_dot_product_collector.sv
module tb_dot_product_collector;

    localparam int VS    = 6;
    localparam int DEPTH = 4;

    logic        clk;
    logic        resetn;
    logic [17:0] dp_dout;
    logic        dp_run;
    logic [17:0] out_data;
    logic        out_valid;
    logic        out_ready;
    logic [2:0]  level;
    logic        overflow;
    logic        spacing_err;
    logic        clear;
`ifdef DP_COLLECT_TAG_EN
    logic [7:0]  out_tag;
`endif

    dot_product_collector dut (
        .clk         (clk),
        .resetn      (resetn),
        .dp_dout     (dp_dout),
        .dp_run      (dp_run),
        .out_data    (out_data),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .level       (level),
        .overflow    (overflow),
        .spacing_err (spacing_err),
        .clear       (clear)
`ifdef DP_COLLECT_TAG_EN
        ,
        .out_tag     (out_tag)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model: queue of (result, tag) plus strobe timestamps.
    typedef struct packed {
        logic [17:0] data;
        logic [7:0]  tag;
    } ent_t;

    ent_t       m_q[$];
    logic       m_armed;
    logic       m_ov;
    logic       m_sp;
    logic [7:0] m_tag;
    int         m_cyc;
    int         m_last;

    int n_cmp;
    int n_err;
    int eng_res;   // result the engine will present on its next strobe

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d, want %0d (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    task automatic model_edge();
        logic sp_set;
        logic drop;
        ent_t e;
        m_cyc++;
        if (!resetn) begin
            m_q.delete();
            m_armed = 1'b0;
            m_ov    = 1'b0;
            m_sp    = 1'b0;
            m_tag   = '0;
            return;
        end
        sp_set = 1'b0;
        drop   = 1'b0;
        if (m_armed) begin
            if (dp_run) sp_set = ((m_cyc - m_last) != VS);
            else        sp_set = ((m_cyc - m_last) == VS);
        end
        if (m_q.size() > 0 && out_ready) void'(m_q.pop_front());
        if (dp_run && m_armed) begin
            if (m_q.size() < DEPTH) begin
                e.data = dp_dout;
                e.tag  = m_tag;
                m_q.push_back(e);
            end else begin
                drop = 1'b1;
            end
            m_tag = m_tag + 8'd1;
        end
        if (dp_run) begin
            m_armed = 1'b1;
            m_last  = m_cyc;
        end
        m_ov = drop | (m_ov & ~clear);
        m_sp = sp_set | (m_sp & ~clear);
    endtask

    task automatic compare_all();
        check_eq("valid", 32'(out_valid), 32'(m_q.size() > 0));
        check_eq("level", 32'(level), 32'(m_q.size()));
        if (m_q.size() > 0) begin
            check_eq("data", 32'(out_data), 32'(m_q[0].data));
`ifdef DP_COLLECT_TAG_EN
            check_eq("tag", 32'(out_tag), 32'(m_q[0].tag));
`endif
        end
        check_eq("overflow", 32'(overflow), 32'(m_ov));
        check_eq("spacing", 32'(spacing_err), 32'(m_sp));
    endtask

    task automatic tick(input logic run, input logic [17:0] dout, input logic rdy,
                        input logic clr);
        dp_run    = run;
        dp_dout   = dout;
        out_ready = rdy;
        clear     = clr;
        @(posedge clk);
        model_edge();
        #1;
        compare_all();
    endtask

    function automatic int rand_dot();
        int s;
        s = 0;
        for (int i = 0; i < 3; i++) s += $urandom_range(0, 255) * $urandom_range(0, 255);
        return s;
    endfunction

    function automatic logic rdy_of(input int mode);
        return (mode == 2) ? logic'($urandom_range(0, 1)) : logic'(mode[0]);
    endfunction

    // One engine frame: strobe with the previous result, then VS-1 idle cycles.
    task automatic frame(input int next_val, input logic rdy_strobe, input int rdy_mode,
                         input logic clr_last);
        tick(1'b1, 18'(eng_res), rdy_strobe, 1'b0);
        eng_res = next_val;
        for (int i = 0; i < VS - 1; i++) begin
            tick(1'b0, 18'($urandom), rdy_of(rdy_mode), clr_last && (i == VS - 2));
        end
    endtask

    task automatic do_reset();
        resetn = 1'b0;
        tick(1'b0, 18'($urandom), 1'b0, 1'b0);
        resetn  = 1'b1;
        eng_res = 0;
    endtask

    int res[5];

    initial begin
        n_cmp = 0; n_err = 0; m_cyc = 0; m_last = 0;
        m_armed = 1'b0; m_ov = 1'b0; m_sp = 1'b0; m_tag = '0;
        dp_run = 1'b0; dp_dout = '0; out_ready = 1'b0; clear = 1'b0;
        eng_res = 0;

        // Reset state
        resetn = 1'b0;
        tick(1'b0, 18'h3ffff, 1'b1, 1'b0);
        tick(1'b0, 18'h3ffff, 1'b1, 1'b0);
        check_eq("rst_data", 32'(out_data), 32'd0);
        check_eq("rst_valid", 32'(out_valid), 32'd0);
        check_eq("rst_level", 32'(level), 32'd0);
        check_eq("rst_flags", 32'({overflow, spacing_err}), 32'd0);
        resetn = 1'b1;

        // A=(1,2,3) B=(4,5,6): arming strobe discarded, then 32 captured
        tick(1'b1, 18'd0, 1'b0, 1'b0);
        check_eq("arm_nocap", 32'(level), 32'd0);
        for (int i = 0; i < VS - 1; i++) tick(1'b0, 18'($urandom), 1'b0, 1'b0);
        tick(1'b1, 18'(1*4 + 2*5 + 3*6), 1'b0, 1'b0);
        check_eq("dp_32", 32'(out_data), 32'd32);
        check_eq("dp_32_lvl", 32'(level), 32'd1);
        tick(1'b0, 18'($urandom), 1'b1, 1'b0);
        check_eq("pop_lvl", 32'(level), 32'd0);
        check_eq("pop_valid", 32'(out_valid), 32'd0);
        for (int i = 0; i < VS - 2; i++) tick(1'b0, 18'($urandom), 1'b1, 1'b0);

        // All elements 255
        eng_res = 3 * 255 * 255;
        frame(rand_dot(), 1'b0, 0, 1'b0);
        check_eq("max_res", 32'(out_data), 32'd195075);
        frame(rand_dot(), 1'b0, 1, 1'b0);

        // Overflow: fresh reset, five captures with no reads
        do_reset();
        frame(rand_dot(), 1'b0, 0, 1'b0);
        for (int f = 0; f < 4; f++) begin
            res[f] = eng_res;
            frame(rand_dot(), 1'b0, 0, 1'b0);
        end
        res[4] = eng_res;
        tick(1'b1, 18'(eng_res), 1'b0, 1'b0);
        eng_res = rand_dot();
        check_eq("ovf_lvl", 32'(level), 32'd4);
        check_eq("ovf_flag", 32'(overflow), 32'd1);
        check_eq("ovf_head", 32'(out_data), 32'(res[0]));
`ifdef DP_COLLECT_TAG_EN
        check_eq("ovf_tag0", 32'(out_tag), 32'd0);
`endif
        for (int i = 0; i < VS - 1; i++) begin
            tick(1'b0, 18'($urandom), 1'b1, i == VS - 2);
        end
        check_eq("clr_ovf", 32'(overflow), 32'd0);
        check_eq("drained", 32'(level), 32'd0);
        frame(rand_dot(), 1'b0, 0, 1'b0);
`ifdef DP_COLLECT_TAG_EN
        check_eq("tag_gap", 32'(out_tag), 32'd5);
`endif

        // Full with pop exactly on the capture edge
        for (int f = 0; f < 3; f++) frame(rand_dot(), 1'b0, 0, 1'b0);
        check_eq("full_lvl", 32'(level), 32'd4);
        res[0] = int'(out_data);
        frame(rand_dot(), 1'b1, 0, 1'b0);
        check_eq("fullpop_lvl", 32'(level), 32'd4);
        check_eq("fullpop_ovf", 32'(overflow), 32'd0);
        check_eq("fullpop_adv", 32'(out_data != 18'(res[0])), 32'd1);
        frame(rand_dot(), 1'b0, 1, 1'b0);

        // Early strobe three cycles after a strobe
        tick(1'b1, 18'(eng_res), 1'b1, 1'b0);
        eng_res = rand_dot();
        tick(1'b0, 18'($urandom), 1'b1, 1'b0);
        tick(1'b0, 18'($urandom), 1'b1, 1'b0);
        check_eq("early_pre", 32'(spacing_err), 32'd0);
        frame(rand_dot(), 1'b1, 1, 1'b1);
        check_eq("early_clr", 32'(spacing_err), 32'd0);
        // Suppressed strobe: error once the due cycle passes
        tick(1'b1, 18'(eng_res), 1'b1, 1'b0);
        eng_res = rand_dot();
        for (int i = 0; i < VS - 1; i++) tick(1'b0, 18'($urandom), 1'b1, 1'b0);
        check_eq("miss_pre", 32'(spacing_err), 32'd0);
        tick(1'b0, 18'($urandom), 1'b1, 1'b0);
        check_eq("miss_flag", 32'(spacing_err), 32'd1);
        for (int i = 0; i < VS - 1; i++) tick(1'b0, 18'($urandom), 1'b1, 1'b0);
        frame(rand_dot(), 1'b1, 1, 1'b1);
        frame(rand_dot(), 1'b0, 0, 1'b0);
        frame(rand_dot(), 1'b0, 0, 1'b0);

        // Mid-frame reset with two entries held
        check_eq("hold2", 32'(level), 32'd2);
        tick(1'b1, 18'(eng_res), 1'b0, 1'b0);
        tick(1'b0, 18'($urandom), 1'b0, 1'b0);
        tick(1'b0, 18'($urandom), 1'b0, 1'b0);
        check_eq("pre_rst_ovf", 32'(overflow), 32'd0);
        do_reset();
        check_eq("mrst_lvl", 32'(level), 32'd0);
        check_eq("mrst_valid", 32'(out_valid), 32'd0);
        check_eq("mrst_flags", 32'({overflow, spacing_err}), 32'd0);
        frame(rand_dot(), 1'b0, 0, 1'b0);
        check_eq("mrst_nocap", 32'(level), 32'd0);

        // Randomized traffic
        for (int f = 0; f < 200; f++) begin
            frame(rand_dot(), rdy_of(2), 2, ($urandom_range(0, 15) == 0));
            if ($urandom_range(0, 19) == 0) tick(1'b0, 18'($urandom), rdy_of(2), 1'b0);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/dot_product_collector.md
Name: dot_product_collector

Overview:
- Downstream stage of the 3-element serial dot-product engine (8-bit elements, 18-bit result).
- Samples the engine's result bus and frame-start strobe, and discards the post-reset dummy result.
- Buffers completed results in a small first-word-fall-through FIFO with a valid/ready output.
- Flags dropped results (overflow) and strobe-timing violations (spacing error).

Parameters:
DOUT_WIDTH, 18, width of engine result and out_data
VECTOR_SIZE, 6, engine cycles per frame (3 A elements + 3 B elements); expected strobe period
FIFO_DEPTH, 4, result buffer entries; power of 2, >= 2
TAG_WIDTH, 8, sequence-tag width (used only with optional feature)

Ports:
clk  in  1  clock
resetn  in  1  reset, synchronous, active-low; shared with the engine
dp_dout  in  DOUT_WIDTH  engine result bus
dp_run  in  1  engine frame-start strobe; high one cycle per frame
out_data  out  DOUT_WIDTH  FIFO head result
out_valid  out  1  FIFO non-empty
out_ready  in  1  consumer accepts head this cycle
level  out  $clog2(FIFO_DEPTH)+1  current FIFO occupancy
overflow  out  1  sticky: a result was dropped
spacing_err  out  1  sticky: dp_run period != VECTOR_SIZE
clear  in  1  clears both sticky flags

Behaviour:
- Reset values: out_data=0, out_valid=0, level=0, overflow=0, spacing_err=0; internal armed=0, gap=0, tag=0; FIFO storage cleared.
- Engine timing: dp_dout and dp_run update on the same edge. The edge sampling dp_run=1 also sees the finished result on dp_dout.
- armed: set on the first sampled dp_run=1 after reset. That strobe carries the engine's reset value 0 and is not captured.
- Capture event: posedge with dp_run=1 and armed=1. dp_dout is written to the FIFO tail.
- Latency: the result is visible on out_data with out_valid=1 one cycle after the capture edge when the FIFO was empty.
- FIFO is first-word fall-through. out_data = head entry. Pop on out_valid & out_ready.
- Full with capture and no pop: the new result is dropped and overflow is set. Contents are unchanged and level stays FIFO_DEPTH.
- Full with capture and pop in the same cycle: both happen, with no overflow and no level change.
- Empty with pop request: ignored (out_valid=0).
- level: +1 on push only, -1 on pop only, unchanged on both or neither.
- gap counter, active once armed:
  - cleared to 0 on dp_run=1; otherwise increments, saturating at VECTOR_SIZE.
  - spacing_err set if dp_run=1 with gap != VECTOR_SIZE-1.
  - spacing_err set if gap == VECTOR_SIZE-1 with dp_run=0 (missing strobe).
- Captures still occur after a spacing error. The flag is diagnostic only.
- clear=1 zeroes both sticky flags next cycle. If a set condition occurs in the same cycle, set wins.
- Reset mid-operation: FIFO is flushed, flags are cleared, armed=0. The first strobe after reset is discarded again, matching the engine's own restart.
- No arithmetic is performed on data. Widths pass through unchanged.

Optional Feature:
- Macro: DP_COLLECT_TAG_EN.
- When defined:
  - adds output port out_tag, TAG_WIDTH bits.
  - a TAG_WIDTH-bit counter increments on every capture event, including dropped ones, and wraps to 0.
  - each FIFO entry stores the tag value at capture; out_tag presents the head entry's tag; reset value 0.
  - dropped results show as gaps in the tag sequence.
- When undefined: no port, no counter, no tag storage; all other behaviour is identical.

Test Plan:
- Reset, then feed engine A=(1,2,3) B=(4,5,6) → first strobe discarded; one entry out_data=32, level=1 after the second strobe; pop → level=0, out_valid=0.
- All elements 255 → out_data=195075 (0x2FA03), no truncation.
- out_ready=0 for 5 frames → level=4, overflow=1, entries hold results 1-4 in order. With DP_COLLECT_TAG_EN, tags are 0,1,2,3; after draining, the next result has tag 5. Pulse clear → overflow=0.
- FIFO full, out_ready=1 exactly on the capture edge → level stays 4, overflow stays 0, head advances by one.
- Inject an extra dp_run 3 cycles after a strobe → spacing_err=1. Clear, then suppress one strobe → spacing_err=1 at gap=5.
- Hold 2 entries, assert resetn=0 for one cycle mid-frame → level=0, out_valid=0, flags 0; the next strobe with dp_dout=0 is not captured.
